// File: rtl/bin_to_digit_codes_pkg.sv
// Shared display codes and converter state encoding for the binary-to-digit-code block.
package bin_to_digit_codes_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd12;
  localparam logic [CODE_W-1:0] CODE_OVF   = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FMT   = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_digit_codes_bcd_adj3.sv
// Double-dabble correction cell: nibbles of 5 or more get +3 before the next shift.
module bcd_adj3 (
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  assign nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;

endmodule

// File: rtl/bin_to_digit_codes.sv
// Sequential binary-to-BCD converter producing four seven-segment digit codes,
// with optional leading-zero blanking and an overflow pattern.
//
// state    | meaning
// ST_IDLE  | waiting for start; digits hold the last result
// ST_SHIFT | one double-dabble shift per clock, IN_W clocks
// ST_FMT   | apply overflow/blanking, publish digits, pulse done
module bin_to_digit_codes
  import bin_to_digit_codes_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  input  logic            blank_lz,
  output logic            busy,
  output logic            done,
  output logic [3:0]      digit_1,
  output logic [3:0]      digit_2,
  output logic [3:0]      digit_3,
  output logic [3:0]      digit_4
);

  localparam int CNT_W = $clog2(IN_W);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0][3:0]   digit_q, digit_d;

  logic [15:0]       bcd_adj;

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_adj3 u_adj (
      .nibble_i (bcd_q[4*g +: 4]),
      .nibble_o (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= {4{CODE_BLANK}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    digit_d = digit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = bin_in;
          blank_d = blank_lz;
          ovf_d   = (32'(bin_in) > 32'(MAX_VAL));
          bcd_d   = '0;
          cnt_d   = CNT_W'(IN_W - 1);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_FMT;
        end
      end

      ST_FMT: begin
        if (ovf_q) begin
          digit_d = {4{CODE_OVF}};
        end else begin
          digit_d = bcd_q;
          // Blank from the thousands position down until the first nonzero digit; ones stays.
          if (blank_q && bcd_q[15:12] == 4'd0) begin
            digit_d[3] = CODE_BLANK;
            if (bcd_q[11:8] == 4'd0) begin
              digit_d[2] = CODE_BLANK;
              if (bcd_q[7:4] == 4'd0) begin
                digit_d[1] = CODE_BLANK;
              end
            end
          end
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign digit_1 = digit_q[0];
  assign digit_2 = digit_q[1];
  assign digit_3 = digit_q[2];
  assign digit_4 = digit_q[3];

endmodule

// File: tb/tb_bin_to_digit_codes.sv
// Randomized self-checking bench for bin_to_digit_codes against an arithmetic digit model.
module tb_bin_to_digit_codes;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        blank_lz = 1'b0;
  logic        busy, done;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;

  int errors = 0;
  int checks = 0;

  bin_to_digit_codes dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .bin_in   (bin_in),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .digit_1  (digit_1),
    .digit_2  (digit_2),
    .digit_3  (digit_3),
    .digit_4  (digit_4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {digit_4,digit_3,digit_2,digit_1} from decimal arithmetic.
  function automatic int model(input int v, input bit blz);
    int d[4];
    if (v > 9999) return 32'hDDDD;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 1000) % 10;
    if (blz) begin
      for (int i = 3; i >= 1; i--) begin
        if (d[i] != 0) break;
        d[i] = 12;
      end
    end
    return (d[3] << 12) | (d[2] << 8) | (d[1] << 4) | d[0];
  endfunction

  function automatic int digits();
    return int'({digit_4, digit_3, digit_2, digit_1});
  endfunction

  task automatic convert(input int v, input bit blz);
    int k;
    int busy_n;
    bin_in   = 14'(v);
    blank_lz = blz;
    start    = 1'b1;
    @(posedge CLK); #1;
    start    = 1'b0;
    // Operand changes and a stray start during busy must not matter.
    bin_in   = 14'($urandom_range(0, 16383));
    blank_lz = 1'($urandom_range(0, 1));
    busy_n   = busy ? 1 : 0;
    for (k = 1; k <= 40; k++) begin
      start = (k == 5);
      @(posedge CLK); #1;
      start = 1'b0;
      if (done) begin
        chk("done_with_busy", busy, 0);
        break;
      end
      if (busy) busy_n++;
    end
    chk("latency", k, 15);
    chk("busy_cycles", busy_n, 15);
    chk("digits", digits(), model(v, blz));
    @(posedge CLK); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin : main
    int q[$];
    int wait_n, ndone, nacc, last_done;
    bit seen;

    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset_state", int'({busy, done, digit_4, digit_3, digit_2, digit_1}), 32'h0CCCC);

    // Idle after reset: nothing changes.
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      chk("idle_hold", int'({busy, done, digit_4, digit_3, digit_2, digit_1}), 32'h0CCCC);
    end

    convert(1234, 0);
    convert(0, 1);
    convert(45, 1);
    convert(1005, 1);
    convert(9999, 0);
    convert(10000, 0);
    convert(16383, 1);
    convert(0, 0);
    convert(700, 1);

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) convert($urandom_range(0, 16383), 1'($urandom_range(0, 1)));
      else            convert($urandom_range(0, 120), 1'($urandom_range(0, 1)));
    end

    // Start held high: a new conversion is accepted every 16 edges.
    wait_n = 0; ndone = 0; nacc = 0; last_done = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (cyc < 100) begin
        start    = 1'b1;
        bin_in   = 14'($urandom_range(0, 16383));
        blank_lz = 1'($urandom_range(0, 1));
        if (wait_n == 0) begin
          q.push_back(model(int'(bin_in), blank_lz));
          nacc++;
          wait_n = 15;
        end else begin
          wait_n--;
        end
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      if (done) begin
        chk("stream_done_with_busy", busy, 0);
        if (q.size() > 0) chk("stream_digits", digits(), q.pop_front());
        else              chk("stream_extra_done", 1, 0);
        if (last_done >= 0) chk("stream_period", cyc - last_done, 16);
        last_done = cyc;
        ndone++;
      end
    end
    chk("stream_done_count", ndone, nacc);
    chk("stream_left_over", q.size(), 0);

    // Reset in the middle of a conversion.
    repeat (3) @(posedge CLK);
    #1;
    bin_in = 14'd1234; blank_lz = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (6) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", digits(), 32'hCCCC);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", int'(seen), 0);
    chk("abort_hold_digits", digits(), 32'hCCCC);
    convert(8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
